// File: rtl/l3_cmd_sched.sv
// L3 command scheduler: hands host commands to the L2 TX framer, tracks the
// response timeout and the completion watchdog, and keeps the status word.
module l3_cmd_sched #(
    parameter int               TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_CYC = 20'd100000,
    parameter logic [15:0]      MAX_EXT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_cmd_vld,
    input  logic [15:0] host_cmd_ext,
    output logic        host_cmd_rdy,
    output logic        l3_en,
    output logic [15:0] l3_extend,
    input  logic        l3_cmd_done,
    input  logic        timer_stop,
    output logic        resp_err,
    output logic [7:0]  sw0,
    output logic [7:0]  sw1,
    output logic        l2_clr,
    output logic        busy,
    output logic [15:0] cmd_cnt,
    output logic [7:0]  err_cnt
);

    // state     | meaning
    // ----------+--------------------------------------------------------
    // IDLE      | ready for a host command
    // ISSUE     | l3_en pulse for an accepted command
    // REJECT    | l3_en + resp_err pulse for an oversize command
    // WAIT      | waiting for first read data (timer_stop) or completion
    // RUN       | data flowing, completion watchdog running
    // ERR_WAIT  | resp_err held until the framer finishes its error frame
    // ABORT     | l2_clr pulse to clear a hung framer
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_REJECT,
        ST_WAIT,
        ST_RUN,
        ST_ERR_WAIT,
        ST_ABORT
    } state_t;

    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_ONE;

    state_t           state;
    logic [TMO_W-1:0] timer;
    logic [TMO_W-1:0] timer_inc;
    logic             tmo_hit;
    logic [7:0]       err_cnt_inc;

    // The terminal compare looks at the incremented value, so the entry cycle
    // of ISSUE/REJECT/timer_stop counts toward the TMO_CYC budget.
    assign timer_inc   = (&timer) ? timer : timer + TMO_ONE;
    assign tmo_hit     = (timer_inc == TMO_LAST);
    assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            l3_extend <= '0;
            sw0       <= 8'h90;
            sw1       <= 8'h00;
            cmd_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_cmd_vld) begin
                        cmd_cnt <= cmd_cnt + 16'd1;
                        sw1     <= 8'h00;
                        if (host_cmd_ext <= MAX_EXT) begin
                            l3_extend <= host_cmd_ext;
                            sw0       <= 8'h90;
                            state     <= ST_ISSUE;
                        end else begin
                            l3_extend <= '0;
                            sw0       <= 8'h67;
                            err_cnt   <= err_cnt_inc;
                            state     <= ST_REJECT;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_REJECT: begin
                    timer <= '0;
                    state <= ST_ERR_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer_inc;
                    if (l3_cmd_done) begin
                        state <= ST_IDLE;
                    end else if (timer_stop) begin
                        timer <= '0;
                        state <= ST_RUN;
                    end else if (tmo_hit) begin
                        sw0     <= 8'h6F;
                        sw1     <= 8'h00;
                        err_cnt <= err_cnt_inc;
                        timer   <= '0;
                        state   <= ST_ERR_WAIT;
                    end
                end
                ST_RUN, ST_ERR_WAIT: begin
                    timer <= timer_inc;
                    if (l3_cmd_done) begin
                        state <= ST_IDLE;
                    end else if (tmo_hit) begin
                        state <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    sw0     <= 8'h6F;
                    sw1     <= 8'h01;
                    err_cnt <= err_cnt_inc;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_cmd_rdy = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign l3_en        = (state == ST_ISSUE) || (state == ST_REJECT);
    assign resp_err     = (state == ST_REJECT) || (state == ST_ERR_WAIT);
    assign l2_clr       = (state == ST_ABORT);

endmodule

// File: tb/tb_l3_cmd_sched.sv
// Directed bench for l3_cmd_sched with TMO_CYC=16: table of command scenarios
// plus hand-written sequences for held vld, mid-command reset and err_cnt saturation.
module tb_l3_cmd_sched;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_cmd_vld;
    logic [15:0] host_cmd_ext;
    logic        host_cmd_rdy;
    logic        l3_en;
    logic [15:0] l3_extend;
    logic        l3_cmd_done;
    logic        timer_stop;
    logic        resp_err;
    logic [7:0]  sw0;
    logic [7:0]  sw1;
    logic        l2_clr;
    logic        busy;
    logic [15:0] cmd_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    l3_cmd_sched #(
        .TMO_W   (20),
        .TMO_CYC (20'(TMO)),
        .MAX_EXT (16'd1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_cmd_vld (host_cmd_vld),
        .host_cmd_ext (host_cmd_ext),
        .host_cmd_rdy (host_cmd_rdy),
        .l3_en        (l3_en),
        .l3_extend    (l3_extend),
        .l3_cmd_done  (l3_cmd_done),
        .timer_stop   (timer_stop),
        .resp_err     (resp_err),
        .sw0          (sw0),
        .sw1          (sw1),
        .l2_clr       (l2_clr),
        .busy         (busy),
        .cmd_cnt      (cmd_cnt),
        .err_cnt      (err_cnt)
    );

    // Cycle offsets are relative to the l3_en cycle (k=0); -1 means never.
    typedef struct {
        string       name;
        logic [15:0] ext;
        int          stop_at;
        int          done_at;
        int          err_at;
        int          clr_at;
        int          idle_at;
        logic [15:0] exp_extend;
        logic [7:0]  exp_sw0;
        logic [7:0]  exp_sw1;
        int          err_delta;
    } vec_t;

    vec_t        tbl[9];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] exp_cmd = '0;
    logic [7:0]  exp_err = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bump_err(input int d);
        for (int i = 0; i < d; i++) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (host_cmd_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (host_cmd_rdy !== 1'b1) begin
            n_fail++;
            n_vec++;
            $display("FAIL %s: rdy never returned, got %b expected 1", name, host_cmd_rdy);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " rdy"},     32'(host_cmd_rdy), 32'd1);
        chk({name, " l3_en"},   32'(l3_en),        32'd0);
        chk({name, " extend"},  32'(l3_extend),    32'd0);
        chk({name, " resp_err"},32'(resp_err),     32'd0);
        chk({name, " l2_clr"},  32'(l2_clr),       32'd0);
        chk({name, " busy"},    32'(busy),         32'd0);
        chk({name, " sw0"},     32'(sw0),          32'h90);
        chk({name, " sw1"},     32'(sw1),          32'h00);
        chk({name, " cmd_cnt"}, 32'(cmd_cnt),      32'd0);
        chk({name, " err_cnt"}, 32'(err_cnt),      32'd0);
    endtask

    task automatic run_row(input vec_t v);
        string nm;
        logic  e_err;
        wait_idle(v.name);
        host_cmd_vld = 1'b1;
        host_cmd_ext = v.ext;
        exp_cmd      = exp_cmd + 16'd1;
        for (int k = 0; k <= v.idle_at; k++) begin
            @(negedge clk);
            if (k == 0) host_cmd_vld = 1'b0;
            nm    = $sformatf("%s k=%0d", v.name, k);
            e_err = (v.err_at >= 0) && (k >= v.err_at) && (k < v.idle_at) && (k != v.clr_at);
            chk({nm, " l3_en"},    32'(l3_en),    32'(k == 0));
            chk({nm, " resp_err"}, 32'(resp_err), 32'(e_err));
            chk({nm, " l2_clr"},   32'(l2_clr),   32'(k == v.clr_at));
            chk({nm, " busy"},     32'(busy),     32'(k < v.idle_at));
            chk({nm, " rdy"},      32'(host_cmd_rdy), 32'(k >= v.idle_at));
            chk({nm, " extend"},   32'(l3_extend), 32'(v.exp_extend));
            l3_cmd_done = (k == v.done_at);
            timer_stop  = (k == v.stop_at);
        end
        bump_err(v.err_delta);
        chk({v.name, " sw0"},     32'(sw0),     32'(v.exp_sw0));
        chk({v.name, " sw1"},     32'(sw1),     32'(v.exp_sw1));
        chk({v.name, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({v.name, " cmd_cnt"}, 32'(cmd_cnt), 32'(exp_cmd));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        //          name        ext       stop done err clr idle extend    sw0    sw1    derr
        tbl[0] = '{"T1_run",    16'd8,      3,  13, -1, -1, 14, 16'd8,    8'h90, 8'h00, 0};
        tbl[1] = '{"T2_tmo",    16'd8,     -1,  21, 16, -1, 22, 16'd8,    8'h6F, 8'h00, 1};
        tbl[2] = '{"T3_rej",    16'h0500,  -1,   4,  0, -1,  5, 16'd0,    8'h67, 8'h00, 1};
        tbl[3] = '{"T4_abort",  16'd4,      2,  -1, -1, 18, 19, 16'd4,    8'h6F, 8'h01, 1};
        tbl[4] = '{"T5_stop",   16'd8,     15,  20, -1, -1, 21, 16'd8,    8'h90, 8'h00, 0};
        tbl[5] = '{"T5_done",   16'd8,     -1,  15, -1, -1, 16, 16'd8,    8'h90, 8'h00, 0};
        tbl[6] = '{"rej_abort", 16'h0401,  -1,  -1,  0, 16, 17, 16'd0,    8'h6F, 8'h01, 2};
        tbl[7] = '{"max_ext",   16'd1024,   1,   2, -1, -1,  3, 16'd1024, 8'h90, 8'h00, 0};
        tbl[8] = '{"max_p1",    16'd1025,  -1,   1,  0, -1,  2, 16'd0,    8'h67, 8'h00, 1};

        rst_n        = 1'b0;
        host_cmd_vld = 1'b0;
        host_cmd_ext = '0;
        l3_cmd_done  = 1'b0;
        timer_stop   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i]);

        // Held vld: second accept lands in the first IDLE cycle after done, then reset mid-WAIT.
        wait_idle("T6");
        host_cmd_vld = 1'b1;
        host_cmd_ext = 16'd8;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("T6 k=%0d l3_en", k), 32'(l3_en), 32'(k == 0 || k == 5));
            chk($sformatf("T6 k=%0d rdy", k),   32'(host_cmd_rdy), 32'(k == 4));
            if (k == 5) host_cmd_vld = 1'b0;
            l3_cmd_done = (k == 3);
        end
        exp_cmd = exp_cmd + 16'd2;
        chk("T6 cmd_cnt", 32'(cmd_cnt), 32'(exp_cmd));
        chk("T6 busy",    32'(busy),    32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("T6 reset");
        rst_n   = 1'b1;
        exp_cmd = '0;
        exp_err = '0;

        // err_cnt saturation via a run of rejects, each closed by done in ERR_WAIT.
        for (int i = 0; i < 260; i++) begin
            wait_idle("sat");
            host_cmd_vld = 1'b1;
            host_cmd_ext = 16'hFFFF;
            @(negedge clk);
            host_cmd_vld = 1'b0;
            @(negedge clk);
            l3_cmd_done = 1'b1;
            @(negedge clk);
            l3_cmd_done = 1'b0;
            exp_cmd = exp_cmd + 16'd1;
            bump_err(1);
            if (i == 253) chk("sat err_cnt 254", 32'(err_cnt), 32'h FE);
        end
        chk("sat err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("sat cmd_cnt", 32'(cmd_cnt), 32'(exp_cmd));
        chk("sat sw0",     32'(sw0),     32'h67);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
